rate_tick_gen: RTL and testbench
================================

RATE_TICK_GEN -- requirements
Module: rate_tick_gen

Interface
REQ-001 Parameter WIDTH, default 27, counter and divisor width in bits.
REQ-002 Parameter DEFAULT_DIV, default 50000000, period in clk cycles after reset; SHALL fit in WIDTH bits.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  run enable; low aborts and clears any activity.
REQ-006 mode  input  1  0 = periodic, 1 = one-shot; sampled only on IDLE->RUN.
REQ-007 start  input  1  one-shot trigger pulse.
REQ-008 div_in  input  WIDTH  new period in cycles.
REQ-009 div_load  input  1  single-cycle strobe capturing div_in.
REQ-010 tick  output  1  registered one-cycle pulse at end of each period.
REQ-011 clk_out  output  1  registered square wave; toggles on every tick.
REQ-012 busy  output  1  high while in RUN.

Function
REQ-013 States SHALL be IDLE and RUN; mode_q latches mode on IDLE->RUN.
REQ-014 IDLE->RUN SHALL occur when en=1 and either mode=0, or mode=1 with start=1.
REQ-015 RUN->IDLE SHALL occur when en=0, or when mode_q=1 and the tick cycle is reached.
REQ-016 In RUN, if count == div_act-1 then count<=0 and tick<=1, else count<=count+1 and tick<=0.
REQ-017 First tick SHALL be high exactly div_act cycles after the RUN-entry edge; subsequent ticks every div_act cycles.
REQ-018 Active divisor 0 SHALL be treated as 1: tick high every cycle in periodic mode.
REQ-019 div_load SHALL write div_in into shadow register div_shd.
REQ-020 In IDLE, div_act SHALL follow div_shd (or div_in when div_load that cycle) immediately.
REQ-021 In RUN, div_act SHALL update only at the wrap cycle; div_load coinciding with wrap SHALL make div_in the next period.
REQ-022 Counter SHALL never exceed div_act-1; counter arithmetic is WIDTH bits, no overflow possible.
REQ-023 start while RUN in one-shot SHALL clear count to 0 (retrigger); in periodic mode start is ignored.
REQ-024 On RUN->IDLE count SHALL clear to 0, tick SHALL be 0 next cycle; clk_out SHALL hold its level.
REQ-025 Changing mode while RUN SHALL have no effect until the next IDLE->RUN.

Reset
REQ-026 reset SHALL override all inputs: state IDLE, count 0, tick 0, clk_out 0, busy 0.
REQ-027 reset SHALL load div_shd and div_act with DEFAULT_DIV.
REQ-028 reset asserted mid-period SHALL discard the period; no tick in the reset cycle or the cycle after.

Structure
REQ-029 Shared package SHALL hold the state enum (IDLE, RUN) and constant DIV_MIN = 1.
REQ-030 Block SHALL be one module with no sub-module; divisor shadow, counter and FSM coexist.

Verification
REQ-031 WIDTH=8, DEFAULT_DIV=5, en=1, mode=0 from reset release -> tick at cycles 5,10,15; clk_out toggles at each.
REQ-032 Periodic div 5, div_load div_in=3 at cycle 7 -> tick at 10, then 13,16 (change applied at wrap).
REQ-033 mode=1, start at cycle 0, div 4 -> single tick at cycle 4, busy high cycles 1-4, low from 5.
REQ-034 One-shot div 4, second start at cycle 2 -> single tick at cycle 6 only.
REQ-035 Periodic div 5, en low at cycle 8 -> no tick at 10; en high at 12 -> next tick at 17.
REQ-036 div_in=0 loaded in IDLE, periodic run -> tick high every cycle; reset at cycle 3 -> tick, busy, clk_out 0 from cycle 4.

Source files
------------

// File: rtl/rate_tick_gen_pkg.sv
// Shared definitions for the rate tick generator: controller states and divisor floor.
package rate_tick_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DIV_MIN = 1;

endpackage

// File: rtl/rate_tick_gen_if.sv
// Control/status bundle between a rate tick generator and whoever drives it.
interface rate_tick_gen_if #(
    parameter int WIDTH = 27
) ();

    logic             en;
    logic             mode;
    logic             start;
    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             tick;
    logic             clk_out;
    logic             busy;

    modport master (
        output en, mode, start, div_in, div_load,
        input  tick, clk_out, busy
    );

    modport slave (
        input  en, mode, start, div_in, div_load,
        output tick, clk_out, busy
    );

endinterface

// File: rtl/rate_tick_gen.sv
// Programmable periodic / one-shot tick generator with a shadowed divisor and
// a square-wave output that toggles on every tick.
module rate_tick_gen
    import rate_tick_gen_pkg::*;
#(
    parameter int WIDTH       = 27,
    parameter int DEFAULT_DIV = 50000000
) (
    input  logic            clk,
    input  logic            reset,
    rate_tick_gen_if.slave  bus
);

    localparam logic [WIDTH-1:0] DEFAULT_DIV_W = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DIV_MIN_W     = WIDTH'(DIV_MIN);

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             clk_out_q, clk_out_d;
    logic [WIDTH-1:0] div_shd_q, div_shd_d;
    logic [WIDTH-1:0] div_act_q, div_act_d;

    logic [WIDTH-1:0] div_eff;
    logic [WIDTH-1:0] div_next;
    logic             wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            count_q   <= '0;
            tick_q    <= 1'b0;
            clk_out_q <= 1'b0;
            div_shd_q <= DEFAULT_DIV_W;
            div_act_q <= DEFAULT_DIV_W;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            count_q   <= count_d;
            tick_q    <= tick_d;
            clk_out_q <= clk_out_d;
            div_shd_q <= div_shd_d;
            div_act_q <= div_act_d;
        end
    end

    // A zero divisor behaves as one; a load strobe bypasses the shadow so it
    // can take effect in the same cycle it arrives.
    always_comb begin
        div_eff   = (div_act_q == '0) ? DIV_MIN_W : div_act_q;
        wrap      = (count_q == (div_eff - DIV_MIN_W));
        div_next  = bus.div_load ? bus.div_in : div_shd_q;

        state_d   = state_q;
        mode_d    = mode_q;
        count_d   = count_q;
        tick_d    = 1'b0;
        clk_out_d = clk_out_q;
        div_shd_d = div_next;
        div_act_d = div_act_q;

        case (state_q)
            IDLE: begin
                count_d   = '0;
                div_act_d = div_next;
                if (bus.en && (!bus.mode || bus.start)) begin
                    state_d = RUN;
                    mode_d  = bus.mode;
                end
            end
            RUN: begin
                // A one-shot leaves RUN during the cycle its single tick is visible.
                if (!bus.en || (mode_q && tick_q)) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (mode_q && bus.start) begin
                    count_d = '0;
                end else if (wrap) begin
                    count_d   = '0;
                    tick_d    = 1'b1;
                    clk_out_d = !clk_out_q;
                    div_act_d = div_next;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.tick    = tick_q;
    assign bus.clk_out = clk_out_q;
    assign bus.busy    = (state_q == RUN);

endmodule

// File: tb/tb_rate_tick_gen.sv
// Directed bench for rate_tick_gen; cycle k means the interval right after the
// k-th rising edge following the reset that precedes each scenario.
module tb_rate_tick_gen;

    localparam int WIDTH       = 8;
    localparam int DEFAULT_DIV = 5;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    rate_tick_gen_if #(.WIDTH(WIDTH)) bus ();

    rate_tick_gen #(
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after an edge, so outputs are read well away from it.
    task automatic applyStimulus(input logic r, input logic e, input logic m,
                                 input logic s, input logic ld,
                                 input logic [WIDTH-1:0] d);
        reset        = r;
        bus.en       = e;
        bus.mode     = m;
        bus.start    = s;
        bus.div_load = ld;
        bus.div_in   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkBit(input string tag, input int cyc, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s c%0d observed %0b expected %0b", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input int cyc, input logic expTick,
                               input logic expBusy, input logic expClk);
        checkBit({tag, " tick"}, cyc, bus.tick, expTick);
        checkBit({tag, " busy"}, cyc, bus.busy, expBusy);
        checkBit({tag, " clk_out"}, cyc, bus.clk_out, expClk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset        = 1'b1;
        bus.en       = 1'b0;
        bus.mode     = 1'b0;
        bus.start    = 1'b0;
        bus.div_load = 1'b0;
        bus.div_in   = '0;

        // Reset state, then free-running periodic with the default divisor of 5.
        applyStimulus(1, 1, 0, 0, 0, 8'd0);
        applyStimulus(1, 1, 1, 1, 0, 8'd0);
        checkOutput("reset", -1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c <= 16; c++) begin
            applyStimulus(0, 1, 0, 0, 0, 8'd0);
            checkOutput("periodic", c, (c == 5 || c == 10 || c == 15), 1'b1,
                        ((c >= 5 && c < 10) || c >= 15));
        end

        // Divisor 3 loaded mid-period only takes over at the next wrap.
        applyStimulus(1, 0, 0, 0, 0, 8'd0);
        for (int c = 0; c <= 17; c++) begin
            applyStimulus(0, 1, 0, 0, (c == 7), (c == 7) ? 8'd3 : 8'd0);
            checkBit("divchange tick", c, bus.tick,
                     (c == 5 || c == 10 || c == 13 || c == 16));
        end

        // Load coinciding with a wrap makes the new value the very next period.
        applyStimulus(1, 0, 0, 0, 0, 8'd0);
        for (int c = 0; c <= 12; c++) begin
            applyStimulus(0, 1, 0, 0, (c == 5), (c == 5) ? 8'd2 : 8'd0);
            checkBit("wrapload tick", c, bus.tick,
                     (c == 5 || c == 7 || c == 9 || c == 11));
        end

        // One-shot, divisor 4; mode flips mid-run must not matter.
        applyStimulus(1, 0, 0, 0, 0, 8'd0);
        applyStimulus(0, 0, 0, 0, 1, 8'd4);
        checkOutput("oneshot idle", -1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c <= 8; c++) begin
            applyStimulus(0, 1, !(c >= 1 && c <= 3), (c == 0), 0, 8'd0);
            if (c == 0)
                checkBit("oneshot tick", c, bus.tick, 1'b0);
            else
                checkOutput("oneshot", c, (c == 4), (c <= 4), (c >= 4));
        end

        // One-shot retriggered at cycle 2 delays the single tick to cycle 6.
        applyStimulus(1, 0, 0, 0, 0, 8'd0);
        applyStimulus(0, 0, 0, 0, 1, 8'd4);
        for (int c = 0; c <= 10; c++) begin
            applyStimulus(0, 1, 1, (c == 0 || c == 2), 0, 8'd0);
            if (c == 0)
                checkBit("retrig tick", c, bus.tick, 1'b0);
            else
                checkOutput("retrig", c, (c == 6), (c <= 6), (c >= 6));
        end

        // Enable dropped 8..11 aborts the period; restart at 12 ticks at 17.
        applyStimulus(1, 0, 0, 0, 0, 8'd0);
        for (int c = 0; c <= 18; c++) begin
            applyStimulus(0, !(c >= 8 && c < 12), 0, 0, 0, 8'd0);
            checkOutput("enable", c, (c == 5 || c == 17), !(c >= 8 && c < 12),
                        (c >= 5 && c < 17));
        end

        // Divisor 0 ticks every cycle; reset mid-run clears outputs and restores 5.
        applyStimulus(1, 0, 0, 0, 0, 8'd0);
        applyStimulus(0, 0, 0, 0, 1, 8'd0);
        for (int c = 0; c <= 2; c++) begin
            applyStimulus(0, 1, 0, 0, 0, 8'd0);
            checkOutput("div0", c, (c >= 1), 1'b1, (c == 1));
        end
        for (int c = 3; c <= 4; c++) begin
            applyStimulus(1, 1, 0, 0, 0, 8'd0);
            checkOutput("div0 reset", c, 1'b0, 1'b0, 1'b0);
        end
        for (int c = 5; c <= 11; c++) begin
            applyStimulus(0, 1, 0, 0, 0, 8'd0);
            checkOutput("post reset", c, (c == 10), 1'b1, (c >= 10));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
